// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one cmd_* request into an AW/W/B or AR/R
// exchange and reports it with a one-cycle rsp_valid pulse, aborting after TIMEOUT_CYCLES.
module axi_lite_master #(
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES      = 255
) (
  input  logic                           m_axi_lite_aclk,
  input  logic                           axi_reset,
  // Command / response side
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                    cmd_wdata,
  output logic                           rsp_valid,
  output logic [31:0]                    rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic                           rsp_timeout,
  // Write address channel
  output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic                           m_axi_lite_awvalid,
  input  logic                           m_axi_lite_awready,
  // Write data channel
  output logic [31:0]                    m_axi_lite_wdata,
  output logic                           m_axi_lite_wvalid,
  input  logic                           m_axi_lite_wready,
  // Write response channel
  input  logic [1:0]                     m_axi_lite_bresp,
  input  logic                           m_axi_lite_bvalid,
  output logic                           m_axi_lite_bready,
  // Read address channel
  output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic                           m_axi_lite_arvalid,
  input  logic                           m_axi_lite_arready,
  // Read data channel
  input  logic [31:0]                    m_axi_lite_rdata,
  input  logic [1:0]                     m_axi_lite_rresp,
  input  logic                           m_axi_lite_rvalid,
  output logic                           m_axi_lite_rready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]                    wdata_q, wdata_d;
  logic                           aw_valid_q, aw_valid_d;
  logic                           w_valid_q, w_valid_d;
  logic                           ar_valid_q, ar_valid_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [31:0]                    rdata_q, rdata_d;
  logic [1:0]                     resp_q, resp_d;
  logic                           timeout_q, timeout_d;

  logic active;
  logic expire;
  logic aw_fire;
  logic w_fire;
  logic ar_fire;

  assign aw_fire = aw_valid_q && m_axi_lite_awready;
  assign w_fire  = w_valid_q  && m_axi_lite_wready;
  assign ar_fire = ar_valid_q && m_axi_lite_arready;

  assign active = state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};
  // The counter would reach TIMEOUT_CYCLES on this edge, so leave for DONE on the same edge.
  assign expire = active && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    cnt_d      = active ? cnt_q + 1'b1 : cnt_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          if (cmd_write) begin
            state_d    = WR_REQ;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = RD_REQ;
            ar_valid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_fire) aw_valid_d = 1'b0;
        if (w_fire)  w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_lite_bvalid) begin
          resp_d    = m_axi_lite_bresp;
          rdata_d   = '0;
          timeout_d = 1'b0;
          state_d   = DONE;
        end
      end
      RD_REQ: begin
        if (ar_fire) begin
          ar_valid_d = 1'b0;
          state_d    = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_lite_rvalid) begin
          resp_d    = m_axi_lite_rresp;
          rdata_d   = m_axi_lite_rdata;
          timeout_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A response captured on the final cycle still counts as a normal completion.
    if (expire && (state_d != DONE)) begin
      state_d    = DONE;
      aw_valid_d = 1'b0;
      w_valid_d  = 1'b0;
      ar_valid_d = 1'b0;
      resp_d     = RESP_SLVERR;
      rdata_d    = '0;
      timeout_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge m_axi_lite_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      resp_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      ar_valid_q <= ar_valid_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cmd_ready          = (state_q == IDLE);
  assign rsp_valid          = (state_q == DONE);
  assign rsp_rdata          = rdata_q;
  assign rsp_resp           = resp_q;
  assign rsp_timeout        = timeout_q;

  assign m_axi_lite_awaddr  = addr_q;
  assign m_axi_lite_awvalid = aw_valid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wvalid  = w_valid_q;
  assign m_axi_lite_bready  = (state_q == WR_RESP);
  assign m_axi_lite_araddr  = addr_q;
  assign m_axi_lite_arvalid = ar_valid_q;
  assign m_axi_lite_rready  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: a delay-configurable slave model plus a
// latency/response reference computed from per-channel wait counts.
module tb_axi_lite_master;

  localparam int AW = 8;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          axi_reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic [31:0]   wdata;
  logic [1:0]    bresp = '0, rresp = '0;
  logic          bvalid = 1'b0, rvalid = 1'b0;
  logic [31:0]   rdata = '0;

  always #5 clk = ~clk;

  axi_lite_master #(
    .AXI_LITE_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES     (T)
  ) dut (
    .m_axi_lite_aclk   (clk),
    .axi_reset         (axi_reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_resp          (rsp_resp),
    .rsp_timeout       (rsp_timeout),
    .m_axi_lite_awaddr (awaddr),
    .m_axi_lite_awvalid(awvalid),
    .m_axi_lite_awready(awready),
    .m_axi_lite_wdata  (wdata),
    .m_axi_lite_wvalid (wvalid),
    .m_axi_lite_wready (wready),
    .m_axi_lite_bresp  (bresp),
    .m_axi_lite_bvalid (bvalid),
    .m_axi_lite_bready (bready),
    .m_axi_lite_araddr (araddr),
    .m_axi_lite_arvalid(arvalid),
    .m_axi_lite_arready(arready),
    .m_axi_lite_rdata  (rdata),
    .m_axi_lite_rresp  (rresp),
    .m_axi_lite_rvalid (rvalid),
    .m_axi_lite_rready (rready)
  );

  // Slave configuration, written only by the stimulus block.
  int          s_aw_wait = 0, s_w_wait = 0, s_b_wait = 0, s_ar_wait = 0, s_r_wait = 0;
  logic [1:0]  s_resp  = '0;
  logic [31:0] s_rdata = '0;
  bit          s_stray = 1'b0;

  // Slave state and observations, written only by the slave block.
  int            aw_age = 0, w_age = 0, ar_age = 0, b_age = 0, r_age = 0;
  bit            aw_pend = 0, w_pend = 0, b_active = 0, r_active = 0;
  int            aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, stab_err = 0;
  logic [AW-1:0] hs_awaddr = '0, hs_araddr = '0, prev_awaddr = '0, prev_araddr = '0;
  logic [31:0]   hs_wdata = '0, prev_wdata = '0;
  bit            aw_hold = 0, w_hold = 0, ar_hold = 0;

  // Every decision for a cycle is made at its falling edge; a handshake then occurs at the next rise.
  always @(negedge clk) begin
    if (axi_reset) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
      aw_pend = 0; w_pend = 0; b_active = 0; r_active = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0;
    end else begin
      bvalid = 0; bresp = '0;
      if (b_active) begin
        if (b_age >= s_b_wait) begin
          bvalid = 1; bresp = s_resp;
          if (bready) begin b_active = 0; b_hs++; end
        end else b_age++;
      end else if (s_stray) begin
        bvalid = 1; bresp = 2'b11;
      end

      rvalid = 0; rresp = '0; rdata = '0;
      if (r_active) begin
        if (r_age >= s_r_wait) begin
          rvalid = 1; rresp = s_resp; rdata = s_rdata;
          if (rready) begin r_active = 0; r_hs++; end
        end else r_age++;
      end else if (s_stray) begin
        rvalid = 1; rresp = 2'b11; rdata = 32'hBAD0_BAD0;
      end

      if (aw_hold && awvalid && awaddr !== prev_awaddr) stab_err++;
      if (w_hold && wvalid && wdata !== prev_wdata) stab_err++;
      if (ar_hold && arvalid && araddr !== prev_araddr) stab_err++;

      awready = 0;
      if (awvalid) begin
        if (aw_age >= s_aw_wait) begin
          awready = 1; aw_hs++; hs_awaddr = awaddr; aw_age = 0; aw_pend = 1;
        end else aw_age++;
      end else aw_age = 0;
      aw_hold = awvalid && !awready; prev_awaddr = awaddr;

      wready = 0;
      if (wvalid) begin
        if (w_age >= s_w_wait) begin
          wready = 1; w_hs++; hs_wdata = wdata; w_age = 0; w_pend = 1;
        end else w_age++;
      end else w_age = 0;
      w_hold = wvalid && !wready; prev_wdata = wdata;

      if (aw_pend && w_pend) begin
        aw_pend = 0; w_pend = 0; b_active = 1; b_age = 0;
      end

      arready = 0;
      if (arvalid) begin
        if (ar_age >= s_ar_wait) begin
          arready = 1; ar_hs++; hs_araddr = araddr; ar_age = 0; r_active = 1; r_age = 0;
        end else ar_age++;
      end else ar_age = 0;
      ar_hold = arvalid && !arready; prev_araddr = araddr;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-cycle trace of master outputs for the last transaction, indexed by cycles after accept.
  logic          tr_aw [0:63];
  logic          tr_w  [0:63];
  logic          tr_ar [0:63];
  logic          tr_rr [0:63];
  logic [AW-1:0] tr_awaddr [0:63];

  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdat,
                         input int aww, input int ww, input int bw, input int arw, input int rw,
                         input logic [1:0] resp, input logic [31:0] rdat, input string tag);
    int          act, exp_lat, lat, aw0, w0, b0, ar0, r0;
    bit          exp_to, got;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    s_aw_wait = aww; s_w_wait = ww; s_b_wait = bw; s_ar_wait = arw; s_r_wait = rw;
    s_resp = resp; s_rdata = rdat;
    // Reference: cycles spent in request plus response phases decide latency and timeout.
    act       = wr ? (((aww > ww) ? aww : ww) + 1) + (bw + 1) : (arw + 1) + (rw + 1);
    exp_to    = act > T;
    exp_lat   = exp_to ? T + 1 : act + 1;
    exp_resp  = exp_to ? 2'b10 : resp;
    exp_rdata = (exp_to || wr) ? 32'h0 : rdat;
    for (int i = 0; i < 64; i++) begin
      tr_aw[i] = 0; tr_w[i] = 0; tr_ar[i] = 0; tr_rr[i] = 0; tr_awaddr[i] = '0;
    end

    @(negedge clk);
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdat;
    @(posedge clk);
    #1 cmd_valid = 0;

    lat = 0; got = 0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      tr_aw[lat] = awvalid; tr_w[lat] = wvalid; tr_ar[lat] = arvalid; tr_rr[lat] = rready;
      tr_awaddr[lat] = awaddr;
      if (rsp_valid) got = 1;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".rdata"}, rsp_rdata, exp_rdata);
    check({tag, ".resp"}, rsp_resp, exp_resp);
    check({tag, ".timeout"}, rsp_timeout, exp_to);

    @(negedge clk);
    check({tag, ".pulse_end"}, {rsp_valid, cmd_ready}, 2'b01);
    check({tag, ".stable"}, stab_err, 0);
    if (!exp_to) begin
      check({tag, ".aw_hs"}, aw_hs - aw0, wr ? 1 : 0);
      check({tag, ".w_hs"}, w_hs - w0, wr ? 1 : 0);
      check({tag, ".b_hs"}, b_hs - b0, wr ? 1 : 0);
      check({tag, ".ar_hs"}, ar_hs - ar0, wr ? 0 : 1);
      check({tag, ".r_hs"}, r_hs - r0, wr ? 0 : 1);
      if (wr) begin
        check({tag, ".awaddr"}, hs_awaddr, addr);
        check({tag, ".wdata"}, hs_wdata, wdat);
      end else begin
        check({tag, ".araddr"}, hs_araddr, addr);
      end
    end
  endtask

  initial begin
    int          cnt, lat;
    bit          saw;
    logic        wr;
    logic [31:0] d;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.cmd_ready", cmd_ready, 1);
    check("reset.ctrl", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_timeout}, 7'b0);
    check("reset.rdata", rsp_rdata, 0);
    check("reset.resp", rsp_resp, 0);
    axi_reset = 0;
    @(negedge clk);

    // Zero-wait write, AW and W accepted together
    run_txn(1, 8'h08, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'b00, 32'h0, "wr_basic");

    // W accepted two cycles before AW
    run_txn(1, 8'h08, 32'hCAFE_F00D, 2, 0, 0, 0, 0, 2'b00, 32'h0, "wr_w_first");
    check("wr_w_first.c1", {tr_aw[1], tr_w[1]}, 2'b11);
    check("wr_w_first.c2", {tr_aw[2], tr_w[2]}, 2'b10);
    check("wr_w_first.c2_addr", tr_awaddr[2], 8'h08);
    check("wr_w_first.c4", {tr_aw[4], tr_w[4]}, 2'b00);

    // AW accepted before W
    run_txn(1, 8'h3C, 32'h0BAD_CAFE, 0, 3, 1, 0, 0, 2'b01, 32'h0, "wr_aw_first");

    // Read with three data wait cycles
    run_txn(0, 8'h04, 32'h0, 0, 0, 0, 0, 3, 2'b00, 32'h1234_5678, "rd_wait");
    cnt = 0;
    for (int i = 2; i <= 5; i++) if (tr_rr[i] === 1'b1) cnt++;
    check("rd_wait.rready_held", cnt, 4);
    check("rd_wait.rready_drop", tr_rr[6], 0);

    // Read that never gets arready
    run_txn(0, 8'h10, 32'h0, 0, 0, 0, 1000, 0, 2'b00, 32'h0, "rd_timeout");
    cnt = 0;
    for (int i = 1; i <= 17; i++) if (tr_ar[i] === 1'b1) cnt++;
    check("rd_timeout.arvalid_cycles", cnt, 16);
    check("rd_timeout.arvalid_c16", tr_ar[16], 1);
    check("rd_timeout.arvalid_c17", tr_ar[17], 0);

    // Error response on a read
    run_txn(0, 8'h20, 32'h0, 1, 1, 1, 1, 1, 2'b10, 32'h5555_AAAA, "rd_slverr");

    // Reset during WR_RESP
    s_aw_wait = 0; s_w_wait = 0; s_b_wait = 8; s_resp = 2'b00;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h44; cmd_wdata = 32'h1111_2222;
    @(posedge clk);
    #1 cmd_valid = 0;
    lat = 0;
    while (bready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rst_mid.in_wr_resp", bready, 1);
    #2 axi_reset = 1;
    #1;
    check("rst_mid.async_ctrl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 7'b1000000);
    check("rst_mid.async_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, 35'h0);
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw = 1;
    end
    axi_reset = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw = 1;
    end
    check("rst_mid.no_rsp", saw, 0);
    check("rst_mid.cmd_ready", cmd_ready, 1);

    // Randomized traffic against the reference
    for (int n = 0; n < 24; n++) begin
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      run_txn(wr, 8'($urandom), d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), $urandom, "rand");
    end

    // Stray response-channel traffic outside WR_RESP/RD_DATA must be ignored
    s_stray = 1;
    for (int n = 0; n < 8; n++) begin
      wr = 1'($urandom_range(0, 1));
      run_txn(wr, 8'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(1, 3), $urandom_range(0, 3), 2'($urandom_range(0, 2)), $urandom, "stray");
    end
    s_stray = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter AXI_LITE_ADDR_WIDTH, default 8: width of cmd_addr and the AXI-Lite address channels.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: cycles a transaction may spend outside IDLE/DONE before it is aborted.
REQ-003 m_axi_lite_aclk  input  1  the single clock; all logic is on its rising edge.
REQ-004 axi_reset  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when it is high together with cmd_valid.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  AXI_LITE_ADDR_WIDTH  byte address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-012 rsp_resp  output  2  captured BRESP/RRESP, or 2'b10 on timeout.
REQ-013 rsp_timeout  output  1  high with rsp_valid when the transaction was aborted.
REQ-014 m_axi_lite_awaddr/awvalid (out), m_axi_lite_awready (in): AXI-Lite write address channel.
REQ-015 m_axi_lite_wdata[31:0]/wvalid (out), m_axi_lite_wready (in): write data channel (no strobes).
REQ-016 m_axi_lite_bresp[1:0]/bvalid (in), m_axi_lite_bready (out): write response channel.
REQ-017 m_axi_lite_araddr/arvalid (out), m_axi_lite_arready (in): read address channel.
REQ-018 m_axi_lite_rdata[31:0]/rresp[1:0]/rvalid (in), m_axi_lite_rready (out): read data channel.

Function
REQ-019 The FSM SHALL have states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
REQ-020 cmd_ready SHALL equal (state == IDLE).
REQ-021 On a command handshake, the block SHALL register the address and data and go to WR_REQ (cmd_write=1) or RD_REQ (cmd_write=0).
REQ-022 awvalid and wvalid SHALL both be asserted, from a register, on the first WR_REQ cycle.
REQ-023 Each of awvalid and wvalid SHALL clear independently on the cycle after its own valid&ready handshake; the two handshakes may occur in either order or in the same cycle.
REQ-024 WR_REQ SHALL move to WR_RESP once both handshakes are complete.
REQ-025 awaddr/wdata SHALL stay stable while their valid is high.
REQ-026 In WR_RESP, bready SHALL be 1; on bvalid the block SHALL capture bresp, set rsp_rdata=0 and go to DONE.
REQ-027 In RD_REQ, arvalid SHALL be 1 until arready is seen; the block SHALL then go to RD_DATA.
REQ-028 In RD_DATA, rready SHALL be 1; on rvalid the block SHALL capture rdata and rresp and go to DONE.
REQ-029 In DONE, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-030 A cycle counter SHALL clear on command accept and increment each cycle in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
REQ-031 When the counter reaches TIMEOUT_CYCLES, all valid/ready outputs SHALL deassert the next cycle; the block SHALL go to DONE with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
REQ-032 rsp_timeout SHALL be 0 for every normal completion.
REQ-033 Minimum command-accept-to-rsp_valid latency against a zero-wait slave SHALL be 3 cycles for reads and 3 cycles for writes.
REQ-034 Response-channel inputs arriving outside WR_RESP/RD_DATA SHALL be ignored.

Reset
REQ-035 While axi_reset=1, the block SHALL be in state IDLE with cmd_ready=1, all AXI valid/ready outputs 0, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, rsp_resp=0, counter=0.
REQ-036 Reset asserted mid-transaction SHALL abort it immediately with no rsp_valid pulse.

Verification
REQ-037 Write 0xDEADBEEF to address 0x08; slave raises awready and wready together, with bvalid/bresp=00 next cycle -> one AW and one W handshake, rsp_valid pulse with rsp_resp=00 and rsp_rdata=0.
REQ-038 Write where the slave accepts W 2 cycles before AW -> wvalid clears first, awvalid holds with address 0x08, completion normal.
REQ-039 Read from 0x04; slave returns rdata=0x12345678 and rresp=00 after 3 wait cycles -> rsp_rdata=0x12345678, rsp_resp=00, rready held until the rvalid handshake.
REQ-040 Read with the slave never asserting arready and TIMEOUT_CYCLES=16 -> arvalid drops after 16 cycles, rsp_valid with rsp_resp=10 and rsp_timeout=1.
REQ-041 Assert axi_reset during WR_RESP -> outputs reach their reset values asynchronously, no rsp_valid, and cmd_ready=1 after release.
REQ-042 Slave returns rresp=10 -> rsp_resp=10 with rsp_timeout=0.
